vector_mem_sequencer: RTL and testbench

Parametrised vector memory sequencer between the SIMT execute stage and the data cache. It accepts one scalar or vector memory request, issues it to the dcache one active lane at a time, skips lanes whose mask bit is clear, and gathers per-lane load data. It completes with a single-cycle done pulse. It generalises the fixed-thread load/store unit with a lane mask, an explicit ready/done handshake and optional same-address load coalescing.

---
 rtl/vector_mem_sequencer_if.sv | 36 +++
 rtl/vector_mem_sequencer.sv | 145 ++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vector_mem_sequencer_if.sv
// Request, dcache and result bundle of vector_mem_sequencer.
// The master side is the environment: the execute stage plus the dcache.
interface vector_mem_sequencer_if #(
    parameter int THREADS = 4
);
    logic                     reqValid;
    logic                     reqReady;
    logic                     reqWrite;
    logic                     isVector;
    logic [THREADS-1:0]       laneMask;
    logic [THREADS-1:0][31:0] vaddr;
    logic [THREADS-1:0][31:0] vstore;
    logic [31:0]              saddr;
    logic [31:0]              sstore;
    logic                     dmemREN;
    logic                     dmemWEN;
    logic [31:0]              dmemaddr;
    logic [31:0]              dmemstore;
    logic                     dcacheHit;
    logic [31:0]              dmemload;
    logic [THREADS-1:0][31:0] vload;
    logic [31:0]              sload;
    logic                     done;

    modport master (
        output reqValid, reqWrite, isVector, laneMask, vaddr, vstore, saddr, sstore,
        output dcacheHit, dmemload,
        input  reqReady, dmemREN, dmemWEN, dmemaddr, dmemstore, vload, sload, done
    );

    modport slave (
        input  reqValid, reqWrite, isVector, laneMask, vaddr, vstore, saddr, sstore,
        input  dcacheHit, dmemload,
        output reqReady, dmemREN, dmemWEN, dmemaddr, dmemstore, vload, sload, done
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Issues one scalar or masked vector memory request to the dcache lane by lane, gathering loads.
// Optional macro LS_COALESCE_EN: a load hit also serves every later pending lane with the same address.
module vector_mem_sequencer #(
    parameter  int THREADS = 4,
    localparam int LW      = $clog2(THREADS)
) (
    input logic CLK,
    input logic nRST,
    vector_mem_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                   state, next_state;
    logic                     wr, vec;
    logic [THREADS-1:0]       pend;
    logic [LW-1:0]            cur;
    logic [THREADS-1:0][31:0] addr_q, store_q, vload_q;
    logic [31:0]              saddr_q, sstore_q, sload_q;

    logic [THREADS-1:0]       req_mask, shared, remaining, above;
    logic [LW:0]              first_sel, next_sel;
    logic [LW-1:0]            first_lane, next_lane;
    logic                     next_found;
    logic                     ready, done_o, ren, wen;
    logic [31:0]              maddr, mstore;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [LW:0] lowest_set(input logic [THREADS-1:0] m);
        logic [LW:0] r;
        r = '0;
        for (int i = THREADS - 1; i >= 0; i--)
            if (m[i]) r = {1'b1, LW'(i)};
        return r;
    endfunction

    always_comb begin : lane_select
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        req_mask   = bus.isVector ? bus.laneMask : THREADS'(1);
        first_sel  = lowest_set(req_mask);
        first_lane = first_sel[LW-1:0];
        shared     = '0;
`ifdef LS_COALESCE_EN
        if (vec && !wr)
            for (int i = 0; i < THREADS; i++)
                if (i > int'(cur) && pend[i] && addr_q[i] == addr_q[cur]) shared[i] = 1'b1;
`endif
        remaining      = pend & ~shared;
        remaining[cur] = 1'b0;
        above          = '0;
        for (int i = 0; i < THREADS; i++)
            if (i > int'(cur)) above[i] = remaining[i];
        next_sel   = lowest_set(above);
        next_found = next_sel[LW];
        next_lane  = next_sel[LW-1:0];
    end

    always_comb begin : fsm_next
        next_state = state;
        ready      = 1'b0;
        done_o     = 1'b0;
        ren        = 1'b0;
        wen        = 1'b0;
        maddr      = '0;
        mstore     = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.reqValid)
                    next_state = (bus.isVector && bus.laneMask == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                ren    = !wr;
                wen    = wr;
                maddr  = vec ? addr_q[cur]  : saddr_q;
                mstore = vec ? store_q[cur] : sstore_q;
                if (bus.dcacheHit && !next_found) next_state = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: the gathered-load register file is reset too, since its outputs must read 0 after reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr       <= 1'b0;
            vec      <= 1'b0;
            pend     <= '0;
            cur      <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            saddr_q  <= '0;
            sstore_q <= '0;
            vload_q  <= '0;
            sload_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.reqValid) begin
                    wr       <= bus.reqWrite;
                    vec      <= bus.isVector;
                    pend     <= req_mask;
                    cur      <= first_lane;
                    addr_q   <= bus.vaddr;
                    store_q  <= bus.vstore;
                    saddr_q  <= bus.saddr;
                    sstore_q <= bus.sstore;
                    for (int i = 0; i < THREADS; i++)
                        if (!req_mask[i]) vload_q[i] <= '0;
                end
                ISSUE: if (bus.dcacheHit) begin
                    pend <= remaining;
                    if (next_found) cur <= next_lane;
                    if (!wr) begin
                        if (vec) begin
                            vload_q[cur] <= bus.dmemload;
                            for (int i = 0; i < THREADS; i++)
                                if (shared[i]) vload_q[i] <= bus.dmemload;
                        end else begin
                            sload_q <= bus.dmemload;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.reqReady  = ready;
    assign bus.done      = done_o;
    assign bus.dmemREN   = ren;
    assign bus.dmemWEN   = wen;
    assign bus.dmemaddr  = maddr;
    assign bus.dmemstore = mstore;
    assign bus.vload     = vload_q;
    assign bus.sload     = sload_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: directed and random requests against a lane-list model.
module tb_vector_mem_sequencer;
    localparam int THREADS = 4;
`ifdef LS_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_mem_sequencer_if #(.THREADS(THREADS)) bus();
    vector_mem_sequencer #(.THREADS(THREADS)) dut (.CLK(clk), .nRST(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_vload [THREADS];
    logic [31:0] exp_sload;
    logic [31:0] req_addr [THREADS];
    logic [31:0] req_store [THREADS];
    logic [31:0] req_saddr, req_sstore;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.reqWrite = 1'($urandom);
        bus.isVector = 1'($urandom);
        bus.laneMask = THREADS'($urandom);
        for (int j = 0; j < THREADS; j++) begin
            bus.vaddr[j]  = $urandom;
            bus.vstore[j] = $urandom;
        end
        bus.saddr  = $urandom;
        bus.sstore = $urandom;
    endtask

    task automatic check_results(input string pfx);
        for (int j = 0; j < THREADS; j++)
            check($sformatf("%s_vload%0d", pfx, j), bus.vload[j], exp_vload[j]);
        check({pfx, "_sload"}, bus.sload, exp_sload);
    endtask

    // Model: the access list is every active lane in ascending order, minus (when coalescing
    // vector loads) any lane whose address already appears on a lower active lane.
    task automatic run_req(input logic wr, input logic vec, input logic [THREADS-1:0] mask,
                           input int lat_lo, input int lat_hi, input bit fix_data,
                           input logic [31:0] fixed, input int abort_acc);
        int          acc_lane [$];
        int          acc_lat [$];
        logic [31:0] acc_data [$];
        int          acc_of [THREADS];
        logic [THREADS-1:0] eff;
        int total, win, acc_idx, wait_cnt, lane, lead;
        bit got_done;
        eff   = vec ? mask : THREADS'(1);
        total = 0;
        for (int j = 0; j < THREADS; j++) begin
            acc_of[j] = -1;
            if (eff[j]) begin
                lead = j;
                if (COALESCE && vec && !wr)
                    for (int i = 0; i < j; i++)
                        if (lead == j && eff[i] && req_addr[i] == req_addr[j]) lead = i;
                if (lead == j) begin
                    acc_of[j] = acc_lane.size();
                    acc_lane.push_back(j);
                    acc_lat.push_back(int'($urandom_range(lat_hi, lat_lo)));
                    acc_data.push_back(fix_data ? fixed : $urandom);
                    total += acc_lat[acc_lat.size() - 1];
                end else begin
                    acc_of[j] = acc_of[lead];
                end
            end
        end

        @(negedge clk);
        check("req_ready_idle", bus.reqReady, 1);
        bus.reqValid = 1'b1;
        bus.reqWrite = wr;
        bus.isVector = vec;
        bus.laneMask = mask;
        for (int j = 0; j < THREADS; j++) begin
            bus.vaddr[j]  = req_addr[j];
            bus.vstore[j] = req_store[j];
        end
        bus.saddr     = req_saddr;
        bus.sstore    = req_sstore;
        bus.dcacheHit = 1'b0;

        win = 0; acc_idx = 0; wait_cnt = 0; got_done = 1'b0;
        while (!got_done && win < 300) begin
            @(negedge clk);
            win++;
            if (win == 1) begin
                bus.reqValid = 1'b0;
                scramble_inputs();
            end
            bus.dcacheHit = 1'b0;
            bus.dmemload  = $urandom;
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                check("done_cycle", win, total + 1);
                check("done_ren", bus.dmemREN, 0);
                check("done_wen", bus.dmemWEN, 0);
                check("done_addr", bus.dmemaddr, 0);
                bus.dcacheHit = 1'b1;
            end else if (acc_idx >= acc_lane.size()) begin
                check("done_missing", bus.done, 1);
                break;
            end else begin
                lane = acc_lane[acc_idx];
                check("ren", bus.dmemREN, !wr);
                check("wen", bus.dmemWEN, wr);
                check("addr", bus.dmemaddr, vec ? req_addr[lane] : req_saddr);
                check("store", bus.dmemstore, vec ? req_store[lane] : req_sstore);
                if (acc_idx == abort_acc) begin
                    #1 rst_n = 1'b0;
                    #1;
                    check("rst_ready", bus.reqReady, 1);
                    check("rst_done", bus.done, 0);
                    check("rst_ren", bus.dmemREN, 0);
                    check("rst_wen", bus.dmemWEN, 0);
                    check("rst_addr", bus.dmemaddr, 0);
                    check("rst_store", bus.dmemstore, 0);
                    for (int j = 0; j < THREADS; j++) exp_vload[j] = '0;
                    exp_sload = '0;
                    check_results("rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                wait_cnt++;
                if (wait_cnt == acc_lat[acc_idx]) begin
                    bus.dcacheHit = 1'b1;
                    bus.dmemload  = acc_data[acc_idx];
                    acc_idx++;
                    wait_cnt = 0;
                end
            end
        end
        if (!got_done && win >= 300) check("done_timeout", win, total + 1);

        for (int j = 0; j < THREADS; j++) begin
            if (!eff[j]) exp_vload[j] = '0;
            else if (!wr && vec) exp_vload[j] = acc_data[acc_of[j]];
        end
        if (!wr && !vec) exp_sload = acc_data[0];

        @(negedge clk);
        bus.dcacheHit = 1'b0;
        check("access_count", acc_idx, acc_lane.size());
        check("post_ready", bus.reqReady, 1);
        check("post_done", bus.done, 0);
        check_results("post");
    endtask

    initial begin
        bus.reqValid  = 1'b0;
        bus.dcacheHit = 1'b0;
        bus.dmemload  = '0;
        scramble_inputs();
        for (int j = 0; j < THREADS; j++) exp_vload[j] = '0;
        exp_sload = '0;

        repeat (3) @(negedge clk);
        check("reset_ready", bus.reqReady, 1);
        check("reset_done", bus.done, 0);
        check("reset_ren", bus.dmemREN, 0);
        check("reset_wen", bus.dmemWEN, 0);
        check("reset_addr", bus.dmemaddr, 0);
        check("reset_store", bus.dmemstore, 0);
        check_results("reset");
        rst_n = 1'b1;

        // Scalar load at 0x40, two-cycle hit
        for (int j = 0; j < THREADS; j++) begin
            req_addr[j]  = $urandom;
            req_store[j] = $urandom;
        end
        req_saddr = 32'h40; req_sstore = $urandom;
        run_req(1'b0, 1'b0, 4'b0000, 2, 2, 1'b1, 32'hCAFE0001, -1);

        // Vector load, mask 1011, single-cycle hits
        for (int j = 0; j < THREADS; j++) req_addr[j] = 32'(j * 4);
        run_req(1'b0, 1'b1, 4'b1011, 1, 1, 1'b0, '0, -1);

        // Vector store, all lanes, variable latency
        for (int j = 0; j < THREADS; j++) req_store[j] = $urandom;
        run_req(1'b1, 1'b1, 4'b1111, 1, 3, 1'b0, '0, -1);

        // Empty vector mask
        run_req(1'b0, 1'b1, 4'b0000, 1, 1, 1'b0, '0, -1);

        // Stray hits while idle leave results untouched
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            bus.dcacheHit = 1'b1;
            bus.dmemload  = $urandom;
        end
        @(negedge clk);
        bus.dcacheHit = 1'b0;
        check("idle_hit_ren", bus.dmemREN, 0);
        check_results("idle_hit");

        // Reset while issuing lane 2, then a fresh request
        for (int j = 0; j < THREADS; j++) req_addr[j] = 32'h200 + 32'(j * 4);
        run_req(1'b0, 1'b1, 4'b1111, 1, 1, 1'b0, '0, 2);
        run_req(1'b0, 1'b1, 4'b0110, 1, 2, 1'b0, '0, -1);

        // Same-address vector load
        for (int j = 0; j < THREADS; j++) req_addr[j] = 32'h100;
        run_req(1'b0, 1'b1, 4'b1111, 1, 1, 1'b1, 32'h55, -1);

        // Random requests over a small address pool so addresses collide
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < THREADS; j++) begin
                req_addr[j]  = 32'h100 + 32'($urandom_range(2, 0) * 4);
                req_store[j] = $urandom;
            end
            req_saddr  = $urandom;
            req_sstore = $urandom;
            run_req(1'($urandom), 1'($urandom), THREADS'($urandom_range(15, 0)), 1, 3, 1'b0, '0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
